// File: rtl/usrf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usrf_pkg
//  Purpose  : Definitions shared by the serial link endpoints. Holds the
//             framing-mode encodings, which the transmit-side universal shift
//             register also uses, and the receiver state type.
//  Contents : MODE_* encodings, state_t, mode_is_rx()
//  Revision : 1.0 - initial release
// ============================================================================
package usrf_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;  // MSB-first: shift left, new bit into bit 0
  localparam logic [1:0] MODE_SHR  = 2'b10;  // LSB-first: shift right, new bit into MSB
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Only the two shifting modes can open a frame.
  function automatic logic mode_is_rx(input logic [1:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usrf_deser_if.sv
`default_nettype none
// ============================================================================
//  Module   : usrf_deser_if
//  Purpose  : Bundles the serial input and the parallel valid/ready output of
//             the deserializer.
//  Ports    : mode, sdata, svalid, frame_start  - serial side (to receiver)
//             word, word_valid, word_ready      - parallel handshake
//             busy, overrun, clr_overrun        - status and control
//  Modports : master - link/downstream side, slave - the deserializer
//  Revision : 1.0 - initial release
// ============================================================================
interface usrf_deser_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       mode;
  logic             sdata;
  logic             svalid;
  logic             frame_start;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overrun;
  logic             clr_overrun;

  modport master (
    output mode, sdata, svalid, frame_start, word_ready, clr_overrun,
    input  word, word_valid, busy, overrun
  );

  modport slave (
    input  mode, sdata, svalid, frame_start, word_ready, clr_overrun,
    output word, word_valid, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/usrf_out_buf.sv
`default_nettype none
// ============================================================================
//  Module   : usrf_out_buf
//  Purpose  : Single-entry valid/ready output register. Accepts a completed
//             word when empty or when being drained in the same cycle. When
//             full and stalled, it drops the new word and raises a sticky
//             overrun flag.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             i_load       - a completed word is presented this cycle
//             i_data       - the completed word
//             i_ready      - downstream accepts o_word
//             i_clr_ovr    - clear the overrun flag (a set in the same cycle wins)
//             o_word       - held word
//             o_valid      - o_word holds an unconsumed word
//             o_overrun    - sticky dropped-word flag
//  Revision : 1.0 - initial release
// ============================================================================
module usrf_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  input  logic             i_clr_ovr,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;
  logic             w_consume;
  logic             w_accept;
  logic             w_drop;

  assign w_consume = r_valid && i_ready;
  // The slot is free when it is empty or when it is drained on this edge.
  assign w_accept  = i_load && (!r_valid || i_ready);
  assign w_drop    = i_load && r_valid && !i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word  <= i_data;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_word    = r_word;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/usrf_deser.sv
`default_nettype none
// ============================================================================
//  Module   : usrf_deser
//  Purpose  : Serial-to-parallel receiver. Collects WIDTH bits, MSB-first or
//             LSB-first as selected at frame start, and hands each word to
//             downstream through a double-buffered valid/ready output. The
//             next frame can shift in while the previous word waits.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - usrf_deser_if.slave (serial in, word handshake, status)
//  Revision : 1.0 - initial release
// ============================================================================
import usrf_pkg::*;

module usrf_deser #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  usrf_deser_if.slave  bus
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_first;
  logic             w_beat;
  logic             w_start;
  logic             w_start_ok;
  logic             w_done;
  logic             w_busy;

  assign w_beat     = bus.svalid;
  assign w_start    = w_beat && bus.frame_start;
  assign w_start_ok = w_start && mode_is_rx(bus.mode);
  // A frame_start beat always opens a new frame, so it can never complete one.
  assign w_done     = (r_state == SHIFT) && w_beat && !bus.frame_start && (r_cnt == C_LAST);

  // Next shift-register value for a data beat, per the latched mode.
  always_comb begin
    w_shifted = r_shreg;
    if (r_mode == MODE_SHR) begin
      w_shifted = {bus.sdata, r_shreg[WIDTH-1:1]};
    end else begin
      w_shifted = {r_shreg[WIDTH-2:0], bus.sdata};
    end
  end

  // Bit 0 of a new frame lands on an empty register, per the incoming mode.
  always_comb begin
    w_first = '0;
    if (bus.mode == MODE_SHR) begin
      w_first = {bus.sdata, {(WIDTH-1){1'b0}}};
    end else begin
      w_first = {{(WIDTH-1){1'b0}}, bus.sdata};
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_start && !w_start_ok) begin
          w_state_nxt = IDLE;      // restart with a disabled mode discards the frame
        end else if (w_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    if (r_state == SHIFT) begin
      w_busy = 1'b1;
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= MODE_HOLD;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_start_ok) begin
      r_mode  <= bus.mode;
      r_shreg <= w_first;
      r_cnt   <= CNT_W'(1);
    end else if (w_start) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if ((r_state == SHIFT) && w_beat) begin
      if (w_done) begin
        // The completed word leaves through the output buffer on this edge.
        r_shreg <= '0;
        r_cnt   <= '0;
      end else begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  usrf_out_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_done),
    .i_data    (w_shifted),
    .i_ready   (bus.word_ready),
    .i_clr_ovr (bus.clr_overrun),
    .o_word    (bus.word),
    .o_valid   (bus.word_valid),
    .o_overrun (bus.overrun)
  );

  assign bus.busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_usrf_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usrf_deser
//  Purpose  : Directed self-checking bench for usrf_deser with WIDTH=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usrf_deser;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  usrf_deser_if #(.WIDTH(WIDTH)) bus ();

  usrf_deser #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b, input logic fs);
    bus.svalid      = 1'b1;
    bus.sdata       = b;
    bus.frame_start = fs;
    tick();
    bus.svalid      = 1'b0;
    bus.sdata       = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic drain();
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.word !== 4'b0000) begin errors++; $display("FAIL reset_word: got %b want 0000", bus.word); end
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.word_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
  endtask

  task automatic test_msb_first();
    bus.mode = 2'b01;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL msb_busy: got %b want 1", bus.busy); end
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid: got %b want 0", bus.word_valid); end
    beat(1'b1, 1'b0);
    checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b want 1", bus.word_valid); end
    checks++; if (bus.word !== 4'b1011) begin errors++; $display("FAIL msb_word: got %b want 1011", bus.word); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL msb_busy_done: got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.word !== 4'b1011 || bus.word_valid !== 1'b1) begin errors++; $display("FAIL msb_hold: got %b/%b want 1011/1", bus.word, bus.word_valid); end
    drain();
  endtask

  task automatic test_lsb_first();
    bus.mode = 2'b10;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    checks++; if (bus.word !== 4'b1101) begin errors++; $display("FAIL lsb_word: got %b want 1101", bus.word); end
    checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b want 1", bus.word_valid); end
    drain();
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL lsb_consumed: got %b want 0", bus.word_valid); end
  endtask

  task automatic test_gap();
    bus.mode = 2'b01;
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    bus.mode = 2'b10;  // mid-frame mode change must be ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL gap_busy[%0d]: got %b want 1", i, bus.busy); end
    end
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    checks++; if (bus.word !== 4'b1101 || bus.word_valid !== 1'b1) begin errors++; $display("FAIL gap_word: got %b/%b want 1101/1", bus.word, bus.word_valid); end
    drain();
  endtask

  task automatic test_overrun();
    bus.mode = 2'b01;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    bus.clr_overrun = 1'b1;  // clear coincides with the set: set wins
    beat(1'b0, 1'b0);
    bus.clr_overrun = 1'b0;
    checks++; if (bus.word !== 4'b1011) begin errors++; $display("FAIL ovr_word: got %b want 1011", bus.word); end
    checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", bus.word_valid); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    tick();
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    drain();
  endtask

  task automatic test_consume_refill();
    bus.mode = 2'b01;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    bus.word_ready = 1'b1;
    beat(1'b0, 1'b0);
    bus.word_ready = 1'b0;
    checks++; if (bus.word !== 4'b0110) begin errors++; $display("FAIL refill_word: got %b want 0110", bus.word); end
    checks++; if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL refill_valid: got %b want 1", bus.word_valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL refill_overrun: got %b want 0", bus.overrun); end
    drain();
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL refill_drained: got %b want 0", bus.word_valid); end
  endtask

  task automatic test_restart();
    bus.mode = 2'b01;
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    checks++; if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL restart_partial: valid/busy got %b/%b want 0/1", bus.word_valid, bus.busy); end
    beat(1'b1, 1'b0);
    checks++; if (bus.word !== 4'b0011 || bus.word_valid !== 1'b1) begin errors++; $display("FAIL restart_word: got %b/%b want 0011/1", bus.word, bus.word_valid); end
    drain();
  endtask

  task automatic test_disabled_mode();
    bus.mode = 2'b00;
    beat(1'b1, 1'b1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mode00_busy: got %b want 0", bus.busy); end
    bus.mode = 2'b11;
    beat(1'b1, 1'b1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mode11_busy: got %b want 0", bus.busy); end
    bus.mode = 2'b01;
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    bus.mode = 2'b11;
    beat(1'b0, 1'b1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort11_busy: got %b want 0", bus.busy); end
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b0);
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL abort11_valid: got %b want 0", bus.word_valid); end
  endtask

  task automatic test_reset_midframe();
    bus.mode = 2'b01;
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    beat(1'b1, 1'b0);
    checks++; if (bus.busy !== 1'b1 || bus.word_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: busy/valid got %b/%b want 1/1", bus.busy, bus.word_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.word_valid !== 1'b0 || bus.word !== 4'b0000) begin errors++; $display("FAIL midrst_word: got %b/%b want 0000/0", bus.word, bus.word_valid); end
  endtask

  task automatic test_no_frame_start();
    bus.mode = 2'b01;
    beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nofs_busy: got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL nofs_valid: got %b want 0", bus.word_valid); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.mode        = 2'b00;
    bus.sdata       = 1'b0;
    bus.svalid      = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready  = 1'b0;
    bus.clr_overrun = 1'b0;

    test_reset();
    test_msb_first();
    test_lsb_first();
    test_gap();
    test_overrun();
    test_consume_refill();
    test_restart();
    test_disabled_mode();
    test_reset_midframe();
    test_no_frame_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
